// File: rtl/uart_core.sv
// Full-duplex 8N1 UART with an exported bit clock (sck) that paces the transmitter.
// The receiver runs its own mid-bit sampling divider off a synchronised sin.
module uart_core #(
  parameter int BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  output logic       sout,
  input  logic       tx_data_valid,
  input  logic [7:0] tx_data,
  output logic       rx_data_valid,
  output logic [7:0] rx_data,
  output logic       tx_busy,
  output logic       rx_busy,
  output logic       rx_error,
  output logic       sck,
  output logic       sck_rising_edge
);
  localparam int HALF = BAUD_DIV / 2;
  localparam int CW   = $clog2(BAUD_DIV + 1);

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_LOAD  = 3'd1;
  localparam logic [2:0] TX_START = 3'd2;
  localparam logic [2:0] TX_DATA  = 3'd3;
  localparam logic [2:0] TX_STOP  = 3'd4;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  logic [CW-1:0] sck_cnt_q;
  logic          sck_q, sck_rise_q;
  logic          sck_tick, sck_rise_now;

  logic [2:0]    tx_state_q, tx_state_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic          sout_q, sout_d;

  logic          sin_s1_q, sin_sync_q;
  logic [2:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_error_q, rx_error_d;

  // sck_rise_now is the edge at which sck goes high; TX bit changes land on it too.
  assign sck_tick     = (sck_cnt_q == CW'(HALF - 1));
  assign sck_rise_now = sck_tick & ~sck_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sck_cnt_q  <= '0;
      sck_q      <= 1'b0;
      sck_rise_q <= 1'b0;
    end else begin
      sck_cnt_q  <= sck_tick ? '0 : sck_cnt_q + CW'(1);
      sck_q      <= sck_tick ? ~sck_q : sck_q;
      sck_rise_q <= sck_rise_now;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    sout_d     = sout_q;
    case (tx_state_q)
      TX_IDLE: if (tx_data_valid) begin
        tx_shift_d = tx_data;
        tx_state_d = TX_LOAD;
      end
      TX_LOAD: if (sck_rise_now) begin
        sout_d     = 1'b0;
        tx_state_d = TX_START;
      end
      TX_START: if (sck_rise_now) begin
        sout_d     = tx_shift_q[0];
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_bit_d   = 3'd0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (sck_rise_now) begin
        if (tx_bit_q == 3'd7) begin
          sout_d     = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          sout_d     = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      TX_STOP: if (sck_rise_now) tx_state_d = TX_IDLE;
      default: begin
        tx_state_d = TX_IDLE;
        sout_d     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= 8'h00;
      tx_bit_q   <= 3'd0;
      sout_q     <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      sout_q     <= sout_d;
    end
  end

  // Start is re-checked half a bit in; data and stop are then sampled a full bit apart.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_error_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (!sin_sync_q) begin
        rx_state_d = RX_START;
        rx_cnt_d   = '0;
      end
      RX_START: begin
        if (rx_cnt_q == CW'(HALF - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = sin_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CW'(BAUD_DIV - 1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sin_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CW'(BAUD_DIV - 1)) begin
          rx_cnt_d = '0;
          if (sin_sync_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_error_d = 1'b1;
            rx_state_d = RX_WAIT;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_WAIT: if (sin_sync_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sin_s1_q   <= 1'b1;
      sin_sync_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      sin_s1_q   <= sin;
      sin_sync_q <= sin_s1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_error_q <= rx_error_d;
    end
  end

  assign sout            = sout_q;
  assign sck             = sck_q;
  assign sck_rising_edge = sck_rise_q;
  assign tx_busy         = (tx_state_q != TX_IDLE);
  assign rx_busy         = (rx_state_q != RX_IDLE);
  assign rx_data         = rx_data_q;
  assign rx_data_valid   = rx_valid_q;
  assign rx_error        = rx_error_q;
endmodule

// File: tb/tb_uart_core.sv
// Randomised bench for uart_core: a frame-level model predicts sck, sout and tx_busy
// from cycle arithmetic, and a byte scoreboard predicts every rx pulse.
module tb_uart_core;
  localparam int B    = 16;
  localparam int HALF = B / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sin_drv, loop_en, sin_w;
  logic       sout, tx_data_valid, rx_data_valid, tx_busy, rx_busy, rx_error, sck, sck_rising_edge;
  logic [7:0] tx_data, rx_data;

  assign sin_w = loop_en ? sout : sin_drv;

  uart_core #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin_w), .sout(sout),
    .tx_data_valid(tx_data_valid), .tx_data(tx_data),
    .rx_data_valid(rx_data_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .rx_busy(rx_busy), .rx_error(rx_error),
    .sck(sck), .sck_rising_edge(sck_rising_edge)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycles since reset release; the model derives everything from this count.
  int n;
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) n <= 0;
    else       n <= n + 1;
  end

  bit         m_busy = 0;
  int         m_start;
  logic [9:0] m_frame;
  int         exp_q[$];
  logic [7:0] exp_last = 8'h00;
  int         pop_e;
  logic       exp_sout;

  always @(negedge clk) begin
    if (rst_n) begin
      m_busy   = 0;
      exp_last = 8'h00;
      exp_q.delete();
      check("rst_sout", sout, 1'b1);
      check("rst_sck", {sck, sck_rising_edge}, 2'b00);
      check("rst_busy", {tx_busy, rx_busy}, 2'b00);
      check("rst_rx", {rx_data_valid, rx_error, rx_data}, 10'h000);
    end else begin
      if (m_busy && n >= m_start + 10 * B) m_busy = 0;
      exp_sout = (m_busy && n >= m_start) ? m_frame[(n - m_start) / B] : 1'b1;
      check("sck", sck, ((n / HALF) % 2) == 1);
      check("sck_rising_edge", sck_rising_edge, (n % B) == HALF);
      check("sout", sout, exp_sout);
      check("tx_busy", tx_busy, m_busy);
      if (rx_data_valid && rx_error) check("rx_valid_error_excl", 1'b1, 1'b0);
      if (rx_data_valid || rx_error) begin
        if (exp_q.size() == 0) begin
          check("rx_unexpected_pulse", {rx_data_valid, rx_error}, 2'b00);
        end else begin
          pop_e = exp_q.pop_front();
          check("rx_pulse_kind", {rx_data_valid, rx_error}, (pop_e < 0) ? 2'b01 : 2'b10);
          if (rx_data_valid && pop_e >= 0) begin
            check("rx_byte", rx_data, pop_e);
            exp_last = pop_e[7:0];
          end
        end
      end
      check("rx_data_hold", rx_data, exp_last);
      if (tx_data_valid && !m_busy) begin
        m_busy  = 1;
        m_frame = {1'b1, tx_data, 1'b0};
        m_start = n + 2;
        while (m_start % B != HALF) m_start++;
      end
    end
  end

  bit collect_en = 0;
  bit saw_low    = 0;
  int busy_cnt   = 0;
  bit a5_q[$];
  always @(negedge clk) begin
    if (collect_en && !rst_n) begin
      if (sck_rising_edge && tx_busy) a5_q.push_back(sout);
      if (tx_busy && (saw_low || !sout)) begin
        saw_low = 1;
        busy_cnt++;
      end
    end
  end

  bit abort_rx = 0;

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    exp_q.push_back(stop ? int'(b) : -1);
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < B; c++) begin
        if (abort_rx) begin
          sin_drv = 1'b1;
          return;
        end
        sin_drv = f[k];
        if (k == 3 && c == 0) check("rx_busy_in_frame", rx_busy, 1'b1);
        @(posedge clk); #1;
      end
    end
    sin_drv = 1'b1;
  endtask

  task automatic tx_send(input logic [7:0] b);
    int w = 0;
    while (tx_busy && w < 20 * B) begin
      @(posedge clk); #1;
      w++;
    end
    check("tx_idle_wait", tx_busy, 1'b0);
    tx_data = b;
    tx_data_valid = 1'b1;
    if (loop_en) exp_q.push_back(int'(b));
    @(posedge clk); #1;
    tx_data_valid = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int w = 0;
    while (tx_busy && w < 20 * B) begin
      @(posedge clk); #1;
      w++;
    end
    check("tx_done_wait", tx_busy, 1'b0);
  endtask

  task automatic wait_rx_drain();
    int w = 0;
    while ((exp_q.size() != 0 || rx_busy) && w < 30 * B) begin
      @(posedge clk); #1;
      w++;
    end
    check("rx_drain", exp_q.size(), 0);
  endtask

  int a5_seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    rst_n = 1'b1; sin_drv = 1'b1; loop_en = 1'b0;
    tx_data_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    check("reset_sout", sout, 1'b1);
    check("reset_rx_data", rx_data, 8'h00);
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;

    // RX: 00, FF and random bytes back to back at the bit rate.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    for (int i = 0; i < 10; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    wait_rx_drain();

    // Framing error on 55 leaves rx_data alone; 12 afterwards is received.
    send_frame(8'h55, 1'b0);
    repeat (B) @(posedge clk); #1;
    send_frame(8'h12, 1'b1);
    wait_rx_drain();
    check("rx_after_error", rx_data, 8'h12);

    // Short low glitch is rejected at the half-bit start check.
    begin
      int g = $urandom_range(1, HALF - 1);
      for (int c = 0; c < HALF + 8; c++) begin
        sin_drv = (c < g) ? 1'b0 : 1'b1;
        if (c == 3) check("glitch_busy_seen", rx_busy, 1'b1);
        @(posedge clk); #1;
      end
      check("glitch_rejected", rx_busy, 1'b0);
    end

    // TX A5 with a request during busy that must be ignored.
    a5_q.delete(); saw_low = 0; busy_cnt = 0; collect_en = 1;
    tx_send(8'hA5);
    repeat (3) @(posedge clk); #1;
    tx_data = 8'h3C; tx_data_valid = 1'b1;
    @(posedge clk); #1;
    tx_data_valid = 1'b0;
    wait_tx_idle();
    collect_en = 0;
    check("a5_bit_count", a5_q.size(), 10);
    for (int i = 0; i < 10 && i < a5_q.size(); i++) check("a5_bit", a5_q[i], a5_seq[i]);
    check("a5_busy_len", busy_cnt, 10 * B);

    // Random TX bytes with random idle spacing.
    for (int i = 0; i < 4; i++) begin
      tx_send(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
    end
    wait_tx_idle();

    // Loopback, each request issued in the first idle cycle.
    loop_en = 1'b1;
    tx_send(8'h00);
    tx_send(8'hFF);
    tx_send(8'h3C);
    tx_send(8'h81);
    wait_tx_idle();
    wait_rx_drain();
    check("loopback_last", rx_data, 8'h81);
    loop_en = 1'b0;
    repeat (B) @(posedge clk); #1;

    // Reset in the middle of a TX frame and an RX frame.
    fork
      tx_send(8'hC3);
      send_frame(8'h5A, 1'b1);
      begin
        repeat (5 * B) @(posedge clk); #1;
        check("pre_reset_busy", {tx_busy, rx_busy}, 2'b11);
        abort_rx = 1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b0;
      end
    join
    abort_rx = 0;
    check("post_reset_sout", sout, 1'b1);
    check("post_reset_busy", {tx_busy, rx_busy}, 2'b00);
    check("post_reset_rx_data", rx_data, 8'h00);
    repeat (2 * B) @(posedge clk); #1;
    check("post_reset_rx_idle", rx_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
